// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared types, widths and LED mapping for the adder entry sequencer
package adder_seq_pkg;

    localparam int OPW  = 5;
    localparam int SUMW = 6;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        ADD    = 2'd2,
        SHOW   = 2'd3
    } seq_state_t;

    function automatic logic [3:0] state_led_f(input seq_state_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 2-flop sync, stable-count debounce and one-cycle rising-edge pulse
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             flip;

    assign flip = (sync2_q != deb_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            // The pulse is registered so it appears in the cycle after the level flips.
            pulse_q <= flip && sync2_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (flip) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/adder_entry_sequencer.sv
// rtl/adder_entry_sequencer.sv - time-shared operand entry, add and display sequencing
// Optional running accumulation with saturation enabled by ADDER_ACCUM_EN.
module adder_entry_sequencer
    import adder_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic [OPW-1:0]  SW,
    input  logic            ENTER,
    output logic [SUMW-1:0] disp_a,
    output logic [SUMW-1:0] disp_b,
    output logic [SUMW-1:0] disp_sum,
    output logic            blank_sum,
    output logic [3:0]      state_led,
    output logic            ovf
);

    seq_state_t      state_q;
    logic [SUMW-1:0] a_q;
    logic [OPW-1:0]  b_q;
    logic [SUMW-1:0] sum_q;
    logic            enter_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .btn_i   (ENTER),
        .pulse_o (enter_pulse)
    );

`ifdef ADDER_ACCUM_EN
    logic       ovf_q;
    logic [6:0] sum_ext;

    // a_q can carry a previous sum up to 63, so the raw result needs a seventh bit.
    assign sum_ext = {1'b0, a_q} + {2'b00, b_q};

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (enter_pulse) begin
                    a_q     <= {1'b0, SW};
                    state_q <= WAIT_B;
                end
                WAIT_B: if (enter_pulse) begin
                    b_q     <= SW;
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q   <= sum_ext[6] ? 6'h3F : sum_ext[5:0];
                    if (sum_ext[6]) ovf_q <= 1'b1;
                    state_q <= SHOW;
                end
                SHOW: if (enter_pulse) begin
                    a_q     <= sum_q;
                    state_q <= WAIT_B;
                end
                default: state_q <= WAIT_A;
            endcase
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                WAIT_A: if (enter_pulse) begin
                    a_q     <= {1'b0, SW};
                    state_q <= WAIT_B;
                end
                WAIT_B: if (enter_pulse) begin
                    b_q     <= SW;
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q   <= a_q + {1'b0, b_q};
                    state_q <= SHOW;
                end
                SHOW: if (enter_pulse) begin
                    state_q <= WAIT_A;
                end
                default: state_q <= WAIT_A;
            endcase
        end
    end

    assign ovf = 1'b0;
`endif

    assign disp_a    = (state_q == WAIT_A) ? {1'b0, SW} : a_q;
    assign disp_b    = (state_q == WAIT_B) ? {1'b0, SW} : {1'b0, b_q};
    assign disp_sum  = sum_q;
    assign blank_sum = (state_q != SHOW);
    assign state_led = state_led_f(state_q);

endmodule

// File: tb/tb_adder_entry_sequencer.sv
// tb/tb_adder_entry_sequencer.sv - directed self-checking bench for adder_entry_sequencer
module tb_adder_entry_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sw;
    logic       enter;
    logic [5:0] disp_a, disp_b, disp_sum;
    logic       blank_sum;
    logic [3:0] state_led;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int pulse_snap;

    always #5 clk = ~clk;

    adder_entry_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .SW        (sw),
        .ENTER     (enter),
        .disp_a    (disp_a),
        .disp_b    (disp_b),
        .disp_sum  (disp_sum),
        .blank_sum (blank_sum),
        .state_led (state_led),
        .ovf       (ovf)
    );

    always @(posedge clk) if (dut.enter_pulse) pulse_cnt <= pulse_cnt + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input int hold);
        enter = 1'b1;
        cycles(hold);
        enter = 1'b0;
        cycles(10);
    endtask

    initial begin
        rst = 1'b1; sw = 5'd0; enter = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        chk("reset_led",   {4'd0, state_led}, 8'b0001);
        chk("reset_blank", {7'd0, blank_sum}, 8'd1);
        chk("reset_sum",   {2'd0, disp_sum},  8'd0);
        chk("reset_b",     {2'd0, disp_b},    8'd0);
        chk("reset_ovf",   {7'd0, ovf},       8'd0);

        // Basic 9 + 20
        sw = 5'd9;
        press(10);
        chk("a9_led", {4'd0, state_led}, 8'b0010);
        chk("a9_disp_a", {2'd0, disp_a}, 8'd9);
        sw = 5'd20;
        #1;
        chk("b_live", {2'd0, disp_b}, 8'd20);
        @(negedge clk);
        press(10);
        chk("show_led", {4'd0, state_led}, 8'b1000);
        chk("show_a",   {2'd0, disp_a},    8'd9);
        chk("show_b",   {2'd0, disp_b},    8'd20);
        chk("show_sum", {2'd0, disp_sum},  8'd29);
        chk("show_blank", {7'd0, blank_sum}, 8'd0);
        sw = 5'd3;
        #1;
        chk("show_a_held", {2'd0, disp_a}, 8'd9);
        @(negedge clk);
        press(10);
`ifdef ADDER_ACCUM_EN
        chk("show_next_led", {4'd0, state_led}, 8'b0010);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(1);
`else
        chk("show_next_led", {4'd0, state_led}, 8'b0001);
`endif

        // Bouncing press: exactly one pulse, WAIT_A -> WAIT_B only
        sw = 5'd12;
        pulse_snap = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            enter = ((i % 4) < 2);
            @(negedge clk);
        end
        press(6);
        chk("bounce_pulses", 8'(pulse_cnt - pulse_snap), 8'd1);
        chk("bounce_led", {4'd0, state_led}, 8'b0010);
        chk("bounce_a", {2'd0, disp_a}, 8'd12);

        // Reset mid-sequence
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        sw = 5'd7;
        #1;
        chk("midrst_led",   {4'd0, state_led}, 8'b0001);
        chk("midrst_a",     {2'd0, disp_a},    8'd7);
        chk("midrst_blank", {7'd0, blank_sum}, 8'd1);
        @(negedge clk);

        // SW tracking in WAIT_A without ENTER
        sw = 5'd3;
        #1;
        chk("track3", {2'd0, disp_a}, 8'd3);
        @(negedge clk);
        sw = 5'd17;
        #1;
        chk("track17", {2'd0, disp_a}, 8'd17);
        cycles(5);
        chk("track_led", {4'd0, state_led}, 8'b0001);

        // 31 + 31 without wrap
        sw = 5'd31;
        press(10);
        press(10);
        chk("max_sum", {2'd0, disp_sum}, 8'd62);
        chk("max_led", {4'd0, state_led}, 8'b1000);
        chk("max_ovf", {7'd0, ovf}, 8'd0);

`ifdef ADDER_ACCUM_EN
        press(10);
        chk("acc_led", {4'd0, state_led}, 8'b0010);
        chk("acc_a",   {2'd0, disp_a},    8'd62);
        press(10);
        chk("acc_sat", {2'd0, disp_sum}, 8'd63);
        chk("acc_ovf", {7'd0, ovf}, 8'd1);
        press(10);
        chk("acc_ovf_sticky", {7'd0, ovf}, 8'd1);
        chk("acc_a2", {2'd0, disp_a}, 8'd63);
`else
        press(10);
        chk("wrap_led", {4'd0, state_led}, 8'b0001);
        chk("wrap_ovf", {7'd0, ovf}, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_entry_sequencer.md
Name: adder_entry_sequencer

Overview:
- Sequences operand entry for the 5-bit adding-machine datapath.
- One set of 5 switches is time-shared: operand A is captured on the first ENTER press and operand B on the second. The block then adds them and holds the result until the next press.
- Outputs are 6-bit values and blank flags that feed the existing dual seven-segment display drivers. It sits between the board switches/key and those display drivers.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable clock cycles required before the debounced ENTER level changes; legal range >= 1.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- SW  input  5  shared operand value.
- ENTER  input  1  raw push-button, active-high, asynchronous to CLOCK_50.
- disp_a  output  6  value for the A display pair.
- disp_b  output  6  value for the B display pair.
- disp_sum  output  6  value for the sum display pair.
- blank_sum  output  1  high = sum display must be blanked.
- state_led  output  4  one-hot state indicator: [0]=WAIT_A, [1]=WAIT_B, [2]=ADD, [3]=SHOW.
- ovf  output  1  accumulate saturation flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Input conditioning:
  - ENTER passes through a 2-flop synchronizer.
  - A counter tracks how long the synchronized level has differed from the debounced level. When it reaches DEBOUNCE_CYCLES consecutive cycles, the debounced level flips and the counter clears. Any cycle with no difference clears the counter.
  - A rising edge of the debounced level produces enter_pulse, exactly one cycle wide, in the cycle after the flip.
- Reset: state=WAIT_A; a_reg, b_reg, sum_reg, ovf = 0; synchronizer, debounced level and counter = 0.
  - A button held through reset produces one enter_pulse after sync plus DEBOUNCE_CYCLES. This is the required behaviour.
- FSM (a_reg is 6 bits; b_reg is 5 bits):
  - WAIT_A: on enter_pulse, a_reg <= {0,SW} and go to WAIT_B.
  - WAIT_B: on enter_pulse, b_reg <= SW and go to ADD.
  - ADD: exactly one cycle. sum_reg <= a_reg + b_reg, 6-bit result with no truncation possible (max 31+31=62). Go to SHOW. Any enter_pulse arriving in ADD is dropped.
  - SHOW: on enter_pulse, go to WAIT_A. a_reg, b_reg and sum_reg keep their values until overwritten.
- Outputs (all registered or derived from registered state; no combinational path from ENTER):
  - disp_a = {0,SW} live while in WAIT_A, else a_reg.
  - disp_b = {0,SW} live while in WAIT_B, else {0,b_reg}.
  - disp_sum = sum_reg; blank_sum = 1 in every state except SHOW.
- Latency: a_reg/b_reg update on the edge after the enter_pulse cycle. SHOW is entered 2 cycles after the B-capture pulse.
- RESET asserted mid-sequence: state returns to WAIT_A on the next edge, and any in-flight pulse is discarded.

Optional Feature:
- Macro: ADDER_ACCUM_EN.
- Defined: from SHOW, enter_pulse goes to WAIT_B (not WAIT_A) and a_reg <= sum_reg, giving running accumulation. In ADD, sum_reg = min(a_reg + b_reg, 63); ovf is set sticky when the unsaturated result exceeds 63 and cleared only by RESET.
- Undefined: behaviour is as described above; ovf is constant 0.

Decomposition:
- Package adder_seq_pkg:
  - typedef enum logic [1:0] seq_state_t {WAIT_A, WAIT_B, ADD, SHOW};
  - localparams OPW=5 and SUMW=6;
  - a function mapping state to the 4-bit one-hot LED pattern.
- Sub-module button_conditioner (parameter DEBOUNCE_CYCLES): synchronizer, debounce and rising-edge pulse. It has its own unit bench.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then SW=5'd9 and ENTER held 10 cycles; then SW=5'd20 and a second clean press -> disp_a=9, disp_b=20, disp_sum=29, blank_sum=0, state_led=4'b1000.
- ENTER bouncing 1-0-1-0 with 2-cycle segments, then held 6 cycles -> exactly one enter_pulse, and only WAIT_A to WAIT_B occurs.
- SW=31 for A and SW=31 for B -> disp_sum=62, with no wrap.
- RESET asserted for 1 cycle while in WAIT_B with a_reg=12 -> next cycle state_led=4'b0001, disp_a follows SW, blank_sum=1.
- In WAIT_A, toggle SW 3->17 without pressing ENTER -> disp_a tracks SW the same cycle, and no state change occurs.
- ADDER_ACCUM_EN: enter A=31 then B=31, 31, 31 (sums 62, then 63) -> disp_sum saturates at 63, ovf=1, and remains 1 after a further press.
